// File: rtl/id_ex_stage_pkg.sv
// id_ex_stage_pkg: pipeline constants and types shared by the ID/EX stage and the ALU
// ALU op codes, forwarding-select encoding and the stage control bundle.
package id_ex_stage_pkg;
   localparam logic [3:0] ALU_AND = 4'd0;
   localparam logic [3:0] ALU_OR  = 4'd1;
   localparam logic [3:0] ALU_SUB = 4'd6;
   localparam logic [3:0] ALU_SLT = 4'd7;
   localparam logic [3:0] ALU_NOR = 4'd12;
   localparam logic [3:0] ALU_ADD = 4'd15;

   typedef enum logic [1:0] {FWD_NONE, FWD_EXMEM, FWD_MEMWB} fwd_sel_e;

   typedef struct packed {
      logic       reg_write;
      logic       mem_read;
      logic       mem_write;
      logic       mem_to_reg;
      logic       alu_src;
      logic [3:0] alu_op;
   } ctrl_t;

   function automatic logic [31:0] fwd_mux(input fwd_sel_e s, input logic [31:0] reg_data,
                                           input logic [31:0] ex_data, input logic [31:0] wb_data);
      return s == FWD_EXMEM ? ex_data : s == FWD_MEMWB ? wb_data : reg_data;
   endfunction
endpackage

// File: rtl/id_ex_stage_forward.sv
// forward_unit: picks the bypass source for one EX operand
// in: valid/addr of the operand, EX/MEM and MEM/WB writeback info; out: sel.
module forward_unit
   import id_ex_stage_pkg::*;
(
   input  logic       valid,
   input  logic [4:0] addr,
   input  logic       exmem_reg_write,
   input  logic [4:0] exmem_rd,
   input  logic       memwb_reg_write,
   input  logic [4:0] memwb_rd,
   output fwd_sel_e   sel
);
   // r0 is hardwired zero and bubbles carry no operands, so neither is bypassed
   always_comb
      sel = (!valid || addr == 5'd0)                ? FWD_NONE  :
            (exmem_reg_write && exmem_rd == addr)   ? FWD_EXMEM :
            (memwb_reg_write && memwb_rd == addr)   ? FWD_MEMWB : FWD_NONE;
endmodule

// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register with operand forwarding and load-use bubbling
// in: decoded instruction (in_*), stall, flush, EX/MEM and MEM/WB writeback buses
// out: ALU operands/op, store data, EX control bundle, load_use_hazard, bubble_count.
module id_ex_stage
   import id_ex_stage_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   input  logic [31:0] in_rs_data,
   input  logic [31:0] in_rt_data,
   input  logic [31:0] in_imm,
   input  logic [4:0]  in_rs_addr,
   input  logic [4:0]  in_rt_addr,
   input  logic [4:0]  in_rd_addr,
   input  logic [3:0]  in_alu_op,
   input  logic        in_alu_src,
   input  logic        in_uses_rt,
   input  logic        in_reg_write,
   input  logic        in_mem_read,
   input  logic        in_mem_write,
   input  logic        in_mem_to_reg,
   input  logic        stall,
   input  logic        flush,
   input  logic        exmem_reg_write,
   input  logic [4:0]  exmem_rd,
   input  logic [31:0] exmem_result,
   input  logic        memwb_reg_write,
   input  logic [4:0]  memwb_rd,
   input  logic [31:0] memwb_result,
   output logic [31:0] alu_x,
   output logic [31:0] alu_y,
   output logic [3:0]  alu_op,
   output logic        out_valid,
   output logic [4:0]  out_rd,
   output logic [31:0] out_store_data,
   output logic        out_reg_write,
   output logic        out_mem_read,
   output logic        out_mem_write,
   output logic        out_mem_to_reg,
   output logic        load_use_hazard,
   output logic [15:0] bubble_count
);
   typedef struct packed {
      logic        valid;
      ctrl_t       ctrl;
      logic [31:0] rs_data;
      logic [31:0] rt_data;
      logic [31:0] imm;
      logic [4:0]  rs_addr;
      logic [4:0]  rt_addr;
      logic [4:0]  rd;
   } stage_t;

   stage_t      stage_d, stage_q, cap;
   logic [15:0] bubble_count_d, bubble_count_q;
   logic        hz_bubble;
   logic [31:0] fwd_rs, fwd_rt;
   fwd_sel_e    sel_rs, sel_rt;

   forward_unit u_fwd_rs (
      .valid(stage_q.valid), .addr(stage_q.rs_addr),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .sel(sel_rs)
   );

   forward_unit u_fwd_rt (
      .valid(stage_q.valid), .addr(stage_q.rt_addr),
      .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
      .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .sel(sel_rt)
   );

   // a valid load in EX whose destination is read by the instruction in ID
   assign load_use_hazard = in_valid && stage_q.valid && stage_q.ctrl.mem_read && stage_q.rd != 5'd0 &&
                            (stage_q.rd == in_rs_addr || (in_uses_rt && stage_q.rd == in_rt_addr));

   always_comb begin
      cap.valid      = in_valid;
      cap.ctrl       = in_valid ? {in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg, in_alu_src, in_alu_op} : '0;
      cap.rs_data    = in_rs_data;
      cap.rt_data    = in_rt_data;
      cap.imm        = in_imm;
      cap.rs_addr    = in_rs_addr;
      cap.rt_addr    = in_rt_addr;
      cap.rd         = in_rd_addr;
      hz_bubble      = !flush && !stall && load_use_hazard;
      stage_d        = (flush || hz_bubble) ? '0 : stall ? stage_q : cap;
      bubble_count_d = bubble_count_q + {15'd0, hz_bubble && bubble_count_q != 16'hFFFF};
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         stage_q        <= '0;
         bubble_count_q <= '0;
      end else begin
         stage_q        <= stage_d;
         bubble_count_q <= bubble_count_d;
      end
   end

   // data fields of an invalid slot are still captured, so operands are masked to give bubble outputs of 0
   always_comb begin
      fwd_rs         = fwd_mux(sel_rs, stage_q.rs_data, exmem_result, memwb_result);
      fwd_rt         = fwd_mux(sel_rt, stage_q.rt_data, exmem_result, memwb_result);
      alu_x          = stage_q.valid ? fwd_rs : '0;
      alu_y          = !stage_q.valid ? '0 : stage_q.ctrl.alu_src ? stage_q.imm : fwd_rt;
      out_store_data = stage_q.valid ? fwd_rt : '0;
   end

   assign alu_op         = stage_q.ctrl.alu_op;
   assign out_valid      = stage_q.valid;
   assign out_rd         = stage_q.rd;
   assign out_reg_write  = stage_q.ctrl.reg_write;
   assign out_mem_read   = stage_q.ctrl.mem_read;
   assign out_mem_write  = stage_q.ctrl.mem_write;
   assign out_mem_to_reg = stage_q.ctrl.mem_to_reg;
   assign bubble_count   = bubble_count_q;
endmodule

// File: tb/tb_id_ex_stage.sv
// tb_id_ex_stage: scoreboard bench for the ID/EX stage register
module tb_id_ex_stage;
   import id_ex_stage_pkg::*;

   logic        clk = 0, rst_n = 0;
   logic        in_valid, in_alu_src, in_uses_rt, in_reg_write, in_mem_read, in_mem_write, in_mem_to_reg;
   logic [31:0] in_rs_data, in_rt_data, in_imm;
   logic [4:0]  in_rs_addr, in_rt_addr, in_rd_addr;
   logic [3:0]  in_alu_op;
   logic        stall, flush, exmem_reg_write, memwb_reg_write;
   logic [4:0]  exmem_rd, memwb_rd;
   logic [31:0] exmem_result, memwb_result;
   logic [31:0] alu_x, alu_y, out_store_data;
   logic [3:0]  alu_op;
   logic        out_valid, out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg, load_use_hazard;
   logic [4:0]  out_rd;
   logic [15:0] bubble_count;

   typedef struct {
      string       tag;
      logic        v;
      logic [31:0] x, y, sd;
      logic [3:0]  op;
      logic [4:0]  rd;
      logic [3:0]  ctl;
      logic [15:0] bc;
   } exp_t;

   exp_t        sb[$];
   int          n_chk = 0, n_pass = 0;
   logic [15:0] bc = 0;
   logic [31:0] r_rs, r_rt, r_imm;
   logic [4:0]  r_rd;
   logic [3:0]  r_op;
   logic        r_v, r_src, r_rw, r_mw, r_m2r;

   id_ex_stage dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_rs_data(in_rs_data), .in_rt_data(in_rt_data),
      .in_imm(in_imm), .in_rs_addr(in_rs_addr), .in_rt_addr(in_rt_addr), .in_rd_addr(in_rd_addr),
      .in_alu_op(in_alu_op), .in_alu_src(in_alu_src), .in_uses_rt(in_uses_rt), .in_reg_write(in_reg_write),
      .in_mem_read(in_mem_read), .in_mem_write(in_mem_write), .in_mem_to_reg(in_mem_to_reg),
      .stall(stall), .flush(flush), .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd),
      .exmem_result(exmem_result), .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd),
      .memwb_result(memwb_result), .alu_x(alu_x), .alu_y(alu_y), .alu_op(alu_op), .out_valid(out_valid),
      .out_rd(out_rd), .out_store_data(out_store_data), .out_reg_write(out_reg_write),
      .out_mem_read(out_mem_read), .out_mem_write(out_mem_write), .out_mem_to_reg(out_mem_to_reg),
      .load_use_hazard(load_use_hazard), .bubble_count(bubble_count)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not finish, got running, need finished");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
   endtask

   task automatic push(input string tag, input logic v, input logic [31:0] x, input logic [31:0] y,
                       input logic [31:0] sd, input logic [3:0] op, input logic [4:0] rd,
                       input logic [3:0] ctl, input logic [15:0] b);
      exp_t e;
      e.tag = tag; e.v = v; e.x = x; e.y = y; e.sd = sd; e.op = op; e.rd = rd; e.ctl = ctl; e.bc = b;
      sb.push_back(e);
   endtask

   task automatic tick();
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() == 0) begin
         check("sb_empty", 32'd0, 32'd1);
         return;
      end
      e = sb.pop_front();
      check({e.tag, ".valid"}, out_valid, e.v);
      check({e.tag, ".x"}, alu_x, e.x);
      check({e.tag, ".y"}, alu_y, e.y);
      check({e.tag, ".sd"}, out_store_data, e.sd);
      check({e.tag, ".op"}, alu_op, e.op);
      check({e.tag, ".rd"}, out_rd, e.rd);
      check({e.tag, ".ctl"}, {out_reg_write, out_mem_read, out_mem_write, out_mem_to_reg}, e.ctl);
      check({e.tag, ".bc"}, bubble_count, e.bc);
   endtask

   task automatic drive(input logic v, input logic [4:0] rs_a, input logic [4:0] rt_a, input logic [4:0] rd,
                        input logic [31:0] rs_d, input logic [31:0] rt_d, input logic [31:0] imm,
                        input logic [3:0] op, input logic src, input logic urt, input logic rw,
                        input logic mr, input logic mw, input logic m2r);
      in_valid = v; in_rs_addr = rs_a; in_rt_addr = rt_a; in_rd_addr = rd;
      in_rs_data = rs_d; in_rt_data = rt_d; in_imm = imm; in_alu_op = op;
      in_alu_src = src; in_uses_rt = urt; in_reg_write = rw; in_mem_read = mr;
      in_mem_write = mw; in_mem_to_reg = m2r;
   endtask

   task automatic fwd_off();
      exmem_reg_write = 0; exmem_rd = 0; exmem_result = 0;
      memwb_reg_write = 0; memwb_rd = 0; memwb_result = 0;
   endtask

   task automatic load(input string tag, input logic [4:0] rd);
      drive(1, 1, 2, rd, 32'h100, 32'h5, 32'h8, ALU_ADD, 1, 0, 1, 1, 0, 1);
      push(tag, 1, 32'h100, 32'h8, 32'h5, ALU_ADD, rd, 4'b1101, bc);
      tick();
   endtask

   task automatic bubble(input string tag);
      bc = bc == 16'hFFFF ? bc : bc + 16'd1;
      push(tag, 0, 0, 0, 0, 0, 0, 4'b0000, bc);
      tick();
   endtask

   initial begin
      stall = 0; flush = 0; fwd_off();
      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      rst_n = 0;
      push("reset", 0, 0, 0, 0, 0, 0, 4'b0000, 0);
      tick();
      check("reset.hz", load_use_hazard, 0);
      rst_n = 1;

      drive(1, 1, 2, 2, 32'd5, 32'd9, 32'd7, ALU_ADD, 1, 0, 1, 0, 0, 0);
      push("add", 1, 5, 7, 9, ALU_ADD, 2, 4'b1000, bc);
      tick();

      drive(1, 3, 5, 8, 32'h11, 32'h22, 32'h0, ALU_OR, 0, 1, 1, 0, 0, 0);
      push("fwd_base", 1, 32'h11, 32'h22, 32'h22, ALU_OR, 8, 4'b1000, bc);
      tick();
      stall = 1;
      exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
      memwb_reg_write = 1; memwb_rd = 3; memwb_result = 32'hBB;
      #1 check("fwd_ex_prio", alu_x, 32'hAA);
      check("fwd_ex_rt_none", alu_y, 32'h22);
      exmem_reg_write = 0;
      #1 check("fwd_wb", alu_x, 32'hBB);
      exmem_reg_write = 1; exmem_rd = 5;
      #1 check("fwd_wb_rs", alu_x, 32'hBB);
      check("fwd_ex_store", out_store_data, 32'hAA);
      check("fwd_ex_y", alu_y, 32'hAA);
      stall = 0; fwd_off();

      drive(1, 0, 0, 9, 32'h33, 32'h44, 32'h55, ALU_SUB, 1, 1, 1, 0, 0, 0);
      push("r0", 1, 32'h33, 32'h55, 32'h44, ALU_SUB, 9, 4'b1000, bc);
      tick();
      exmem_reg_write = 1; exmem_rd = 0; exmem_result = 32'hAA;
      memwb_reg_write = 1; memwb_rd = 0; memwb_result = 32'hBB;
      #1 check("r0_no_fwd_x", alu_x, 32'h33);
      check("r0_no_fwd_sd", out_store_data, 32'h44);
      fwd_off();

      drive(0, 3, 3, 3, 32'h66, 32'h77, 32'h88, ALU_ADD, 0, 1, 1, 1, 1, 1);
      push("invalid", 0, 0, 0, 0, 0, 3, 4'b0000, bc);
      tick();
      exmem_reg_write = 1; exmem_rd = 3; exmem_result = 32'hAA;
      #1 check("inv_no_fwd_x", alu_x, 32'h0);
      check("inv_no_fwd_sd", out_store_data, 32'h0);
      fwd_off();

      load("lw4", 4);
      drive(1, 4, 2, 6, 32'h200, 32'h3, 32'h0, ALU_ADD, 0, 1, 1, 0, 0, 0);
      #1 check("lu_hz", load_use_hazard, 1);
      bubble("lu_bubble");
      check("lu_hz_clear", load_use_hazard, 0);
      push("lu_capture", 1, 32'h200, 32'h3, 32'h3, ALU_ADD, 6, 4'b1000, bc);
      tick();

      load("lw7", 7);
      drive(1, 1, 7, 9, 32'h1, 32'h2, 32'h0, ALU_AND, 0, 0, 1, 0, 0, 0);
      #1 check("rt_unused_hz", load_use_hazard, 0);
      in_uses_rt = 1;
      #1 check("rt_used_hz", load_use_hazard, 1);
      stall = 1;
      push("stall_over_hz", 1, 32'h100, 32'h8, 32'h5, ALU_ADD, 7, 4'b1101, bc);
      tick();
      stall = 0;
      check("hz_after_stall", load_use_hazard, 1);
      bubble("rt_bubble");

      load("lw0", 0);
      drive(1, 0, 0, 9, 32'h1, 32'h2, 32'h0, ALU_AND, 0, 1, 1, 0, 0, 0);
      #1 check("lw_r0_hz", load_use_hazard, 0);

      drive(1, 10, 11, 12, 32'hDEAD, 32'hBEEF, 32'h4, ALU_NOR, 1, 1, 1, 0, 1, 0);
      push("sf_load", 1, 32'hDEAD, 32'h4, 32'hBEEF, ALU_NOR, 12, 4'b1010, bc);
      tick();
      stall = 1; flush = 1;
      push("stall_flush", 0, 0, 0, 0, 0, 0, 4'b0000, bc);
      tick();
      stall = 0; flush = 0;
      drive(1, 13, 14, 15, 32'h1234, 32'h5678, 32'h9, ALU_SLT, 0, 1, 1, 0, 0, 0);
      push("hold_load", 1, 32'h1234, 32'h5678, 32'h5678, ALU_SLT, 15, 4'b1000, bc);
      tick();
      stall = 1;
      for (int i = 0; i < 3; i++) begin
         drive(1, 5'(i + 1), 5'(i + 2), 5'(i + 3), $urandom, $urandom, $urandom, 4'(i), 1, 1, 0, 0, 1, 1);
         push("stall_hold", 1, 32'h1234, 32'h5678, 32'h5678, ALU_SLT, 15, 4'b1000, bc);
         tick();
      end
      stall = 0;

      for (int i = 0; i < 24; i++) begin
         r_v = 1'($urandom_range(0, 1)); r_src = 1'($urandom_range(0, 1));
         r_rw = 1'($urandom_range(0, 1)); r_mw = 1'($urandom_range(0, 1)); r_m2r = 1'($urandom_range(0, 1));
         r_rs = $urandom; r_rt = $urandom; r_imm = $urandom;
         r_rd = 5'($urandom_range(0, 31)); r_op = 4'($urandom_range(0, 15));
         drive(r_v, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), r_rd, r_rs, r_rt, r_imm, r_op,
               r_src, 1, r_rw, 0, r_mw, r_m2r);
         push("rand", r_v, r_v ? r_rs : 0, !r_v ? 0 : r_src ? r_imm : r_rt, r_v ? r_rt : 0,
              r_v ? r_op : 4'd0, r_rd, r_v ? {r_rw, 1'b0, r_mw, r_m2r} : 4'b0000, bc);
         tick();
      end

      drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      force dut.bubble_count_d = 16'hFFFE;
      @(posedge clk);
      #1 release dut.bubble_count_d;
      bc = 16'hFFFE;
      check("sat_preload", bubble_count, 16'hFFFE);
      load("sat_lw_a", 4);
      drive(1, 4, 0, 6, 32'h1, 32'h2, 32'h0, ALU_ADD, 0, 0, 1, 0, 0, 0);
      bubble("sat_reach");
      check("sat_max", bubble_count, 16'hFFFF);
      load("sat_lw_b", 4);
      drive(1, 4, 0, 6, 32'h1, 32'h2, 32'h0, ALU_ADD, 0, 0, 1, 0, 0, 0);
      bubble("sat_hold");

      load("rst_lw", 4);
      stall = 1;
      drive(1, 4, 0, 6, 32'h1, 32'h2, 32'h0, ALU_ADD, 0, 0, 1, 0, 0, 0);
      rst_n = 0;
      bc = 0;
      push("rst_mid_stall", 0, 0, 0, 0, 0, 0, 4'b0000, 0);
      tick();
      check("rst_hz", load_use_hazard, 0);
      rst_n = 1; stall = 0;
      drive(1, 2, 3, 5, 32'h77, 32'h88, 32'h3, ALU_ADD, 1, 1, 1, 0, 0, 1);
      push("post_rst", 1, 32'h77, 32'h3, 32'h88, ALU_ADD, 5, 4'b1001, 0);
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
